// File: rtl/kpn_fifo_pkg.sv
// kpn_fifo_pkg: default widths and sizing helper shared by KPN channel modules
package kpn_fifo_pkg;
  localparam int BITS_NUMBER_DEF = 16;
  localparam int FIFO_ELEMENTS_DEF = 5;
  function automatic int cnt_width(input int elems);
    return elems + 1;
  endfunction
endpackage

// File: rtl/kpn_fifo_ram.sv
// kpn_fifo_ram: storage with one synchronous write port and one asynchronous read port
module kpn_fifo_ram #(
  parameter int W  = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: first-word fall-through FIFO with occupancy flags and sticky error flags
module kpn_fifo_channel
  import kpn_fifo_pkg::*;
#(
  parameter int BITS_NUMBER        = BITS_NUMBER_DEF,
  parameter int FIFO_ELEMENTS      = FIFO_ELEMENTS_DEF,
  parameter int ALMOST_FULL_LEVEL  = 2**FIFO_ELEMENTS - 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr,
  input  logic                                   rd,
  input  logic                                   flush,
  input  logic                                   clr_err,
  input  logic [BITS_NUMBER-1:0]                 entry_1,
  output logic [BITS_NUMBER-1:0]                 output_1,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   almost_full,
  output logic                                   almost_empty,
  output logic [cnt_width(FIFO_ELEMENTS)-1:0]    count,
  output logic                                   overflow,
  output logic                                   underflow
);
  localparam int DEPTH = 2**FIFO_ELEMENTS;
  localparam int CW = cnt_width(FIFO_ELEMENTS);
  if (ALMOST_FULL_LEVEL > DEPTH || ALMOST_EMPTY_LEVEL >= DEPTH) begin : g_bad_level
    $error("kpn_fifo_channel: almost-full/almost-empty level out of range");
  end
  logic [FIFO_ELEMENTS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic wr_ok, rd_ok;
  logic [BITS_NUMBER-1:0] rdata;
  always_comb begin
    wr_ok    = wr & ~full;
    rd_ok    = rd & ~empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + FIFO_ELEMENTS'(wr_ok);
    rd_ptr_d = flush ? '0 : rd_ptr_q + FIFO_ELEMENTS'(rd_ok);
    count_d  = flush ? '0 : count_q + CW'(wr_ok) - CW'(rd_ok);
    ovf_d    = (wr & full & ~flush) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
    unf_d    = (rd & empty & ~flush) ? 1'b1 : clr_err ? 1'b0 : unf_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  kpn_fifo_ram #(.W(BITS_NUMBER), .AW(FIFO_ELEMENTS)) u_ram (
    .clk  (clk),
    .we   (wr_ok & ~flush & ~reset),
    .waddr(wr_ptr_q),
    .wdata(entry_1),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  always_comb begin
    full         = count_q == CW'(DEPTH);
    empty        = count_q == '0;
    almost_full  = count_q >= CW'(ALMOST_FULL_LEVEL);
    almost_empty = count_q <= CW'(ALMOST_EMPTY_LEVEL);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
    output_1     = empty ? '0 : rdata;
  end
endmodule
